// File: rtl/sync_fifo_pkg.sv
// Shared constants, types and helpers for the sync_fifo_thresh block.
package sync_fifo_pkg;

   localparam int unsigned DEFAULT_DEPTH = 16;
   localparam int unsigned DEFAULT_WIDTH = 8;

   // The count needs one bit more than the address so that "full" (== depth) is representable
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

   typedef struct packed {
      logic overflow;
      logic underflow;
   } err_flags_t;

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM backing the FIFO.
// Write port is synchronous. The read port is registered by default and becomes
// combinational when SYNC_FIFO_FWFT_EN is defined (first-word fall-through).
module sync_fifo_ram #(
   parameter int unsigned DATA_WIDTH = sync_fifo_pkg::DEFAULT_WIDTH,
   parameter int unsigned DATA_DEPTH = sync_fifo_pkg::DEFAULT_DEPTH,
   parameter int unsigned AW         = $clog2(DATA_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

   // Storage array has no reset; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

`ifdef SYNC_FIFO_FWFT_EN
   logic unused_rd;
   assign unused_rd = ^{rst_n, re};

   assign rdata = mem[raddr];
`else
   // Read-before-write: a same-cycle write to raddr does not bypass into rdata
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end
`endif

endmodule

// File: rtl/sync_fifo_thresh.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty watermarks
// and sticky overflow/underflow flags.
// Optional feature macro: SYNC_FIFO_FWFT_EN (first-word fall-through read path).
module sync_fifo_thresh
   import sync_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = DEFAULT_WIDTH,
   parameter int unsigned DATA_DEPTH   = DEFAULT_DEPTH,
   parameter int unsigned ALMOST_FULL  = 14,
   parameter int unsigned ALMOST_EMPTY = 2,
   localparam int unsigned AW          = $clog2(DATA_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [AW:0]           fifo_cnt,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  clr_err
);

   localparam int unsigned CW = cnt_width(DATA_DEPTH);

   logic [AW-1:0] wr_addr, rd_addr;
   logic [CW-1:0] cnt_q, cnt_d;
   err_flags_t    err_q, err_d;
   logic          wr_acc, rd_acc;

   // Flags decode the registered count directly
   assign full         = (cnt_q == CW'(DATA_DEPTH));
   assign empty        = (cnt_q == '0);
   assign almost_full  = (cnt_q >= CW'(ALMOST_FULL));
   assign almost_empty = (cnt_q <= CW'(ALMOST_EMPTY));

   // A write while full is only safe if a read frees a slot in the same cycle
   assign rd_acc = rd_en & ~empty;
   assign wr_acc = wr_en & (~full | rd_en);

   // Next-state count and sticky error flags (set wins over clear)
   always_comb begin
      cnt_d           = cnt_q + CW'(wr_acc) - CW'(rd_acc);
      err_d.overflow  = (wr_en & ~wr_acc) | (err_q.overflow & ~clr_err);
      err_d.underflow = (rd_en & empty) | (err_q.underflow & ~clr_err);
   end

   // Pointers, count and error flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_addr <= '0;
         rd_addr <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
      end else begin
         if (wr_acc) wr_addr <= wr_addr + 1'b1;
         if (rd_acc) rd_addr <= rd_addr + 1'b1;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   sync_fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DATA_DEPTH (DATA_DEPTH),
      .AW         (AW)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_acc),
      .waddr (wr_addr),
      .wdata (data_in),
      .re    (rd_acc),
      .raddr (rd_addr),
      .rdata (data_out)
   );

`ifdef SYNC_FIFO_FWFT_EN
   assign data_valid = ~empty;
`else
   logic valid_q;

   // data_valid marks the cycle after an accepted read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) valid_q <= 1'b0;
      else        valid_q <= rd_acc;
   end

   assign data_valid = valid_q;
`endif

   assign fifo_cnt  = cnt_q;
   assign overflow  = err_q.overflow;
   assign underflow = err_q.underflow;

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Self-checking bench for sync_fifo_thresh: directed scenarios followed by random
// traffic, all compared each cycle against a queue-based reference model.
// Honours SYNC_FIFO_FWFT_EN if defined at compile time.
module tb_sync_fifo_thresh;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned AF    = 14;
   localparam int unsigned AE    = 2;
   localparam int unsigned AW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic [DW-1:0] data_out;
   logic          data_valid, full, empty, almost_full, almost_empty;
   logic [AW:0]   fifo_cnt;
   logic          overflow, underflow;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [DW-1:0] q[$];
   logic          m_ovf = 1'b0, m_unf = 1'b0, m_valid = 1'b0;
   logic [DW-1:0] m_dout = '0;

   sync_fifo_thresh #(
      .DATA_WIDTH   (DW),
      .DATA_DEPTH   (DEPTH),
      .ALMOST_FULL  (AF),
      .ALMOST_EMPTY (AE)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en        (wr_en),
      .data_in      (data_in),
      .rd_en        (rd_en),
      .data_out     (data_out),
      .data_valid   (data_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .fifo_cnt     (fifo_cnt),
      .overflow     (overflow),
      .underflow    (underflow),
      .clr_err      (clr_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Compare every DUT output against the model
   task automatic chk_all(input string tag);
      int n;
      n = q.size();
      chk({tag, ":cnt"}, 32'(fifo_cnt), 32'(n));
      chk({tag, ":full"}, 32'(full), 32'(n == DEPTH));
      chk({tag, ":empty"}, 32'(empty), 32'(n == 0));
      chk({tag, ":afull"}, 32'(almost_full), 32'(n >= AF));
      chk({tag, ":aempty"}, 32'(almost_empty), 32'(n <= AE));
      chk({tag, ":ovf"}, 32'(overflow), 32'(m_ovf));
      chk({tag, ":unf"}, 32'(underflow), 32'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
      chk({tag, ":valid"}, 32'(data_valid), 32'(n != 0));
      if (n != 0) chk({tag, ":dout"}, 32'(data_out), 32'(q[0]));
`else
      chk({tag, ":valid"}, 32'(data_valid), 32'(m_valid));
      chk({tag, ":dout"}, 32'(data_out), 32'(m_dout));
`endif
   endtask

   // One clock with the given inputs; the model applies the FIFO rules, then outputs are checked
   task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r, input logic c,
                      input string tag);
      logic was_empty, was_full, racc, wacc;
      wr_en = w; data_in = d; rd_en = r; clr_err = c;
      was_empty = (q.size() == 0);
      was_full  = (q.size() == DEPTH);
      racc = r && !was_empty;
      wacc = w && (!was_full || r);
      m_valid = racc;
      if (racc) m_dout = q.pop_front();
      if (wacc) q.push_back(d);
      m_ovf = (w && !wacc) || (m_ovf && !c);
      m_unf = (r && was_empty) || (m_unf && !c);
      @(posedge clk);
      #1;
      chk_all(tag);
   endtask

   task automatic model_reset();
      q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_valid = 1'b0; m_dout = '0;
   endtask

   initial begin
      // Reset state
      #3;
      model_reset();
      chk_all("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk_all("post_reset");

      // Fill 0x00..0x0F, walking the count and watermarks upward
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0, "fill");
      chk("full_at_16", 32'(full), 32'd1);

      // Full: write with simultaneous read is accepted, returns oldest word
      cyc(1'b1, 8'hAA, 1'b1, 1'b0, "full_wr_rd");
      chk("full_wr_rd_cnt", 32'(fifo_cnt), 32'd16);
      chk("full_wr_rd_ovf", 32'(overflow), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
      chk("full_wr_rd_dout", 32'(data_out), 32'h00);
`endif
      // Full: lone write is rejected
      cyc(1'b1, 8'hBB, 1'b0, 1'b0, "full_wr_only");
      chk("overflow_set", 32'(overflow), 32'd1);

      // Drain everything, watermarks walk back down
      for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1, 1'b0, "drain");
      cyc(1'b0, '0, 1'b0, 1'b0, "drain_idle");
      chk("empty_after_drain", 32'(empty), 32'd1);

      // Empty: simultaneous write and read; read rejected, write accepted
      cyc(1'b1, 8'h55, 1'b1, 1'b0, "empty_wr_rd");
      chk("empty_wr_rd_unf", 32'(underflow), 32'd1);
      chk("empty_wr_rd_cnt", 32'(fifo_cnt), 32'd1);
      cyc(1'b0, '0, 1'b1, 1'b0, "read_55");
`ifndef SYNC_FIFO_FWFT_EN
      chk("read_55_dout", 32'(data_out), 32'h55);
`endif

      // Clear both errors, then clear coincident with a fresh overflow
      cyc(1'b0, '0, 1'b0, 1'b1, "clr");
      chk("clr_ovf", 32'(overflow), 32'd0);
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, DW'(8'h80 + i), 1'b0, 1'b0, "refill");
      cyc(1'b1, 8'hCC, 1'b0, 1'b1, "clr_vs_set");
      chk("set_wins", 32'(overflow), 32'd1);
      cyc(1'b0, '0, 1'b0, 1'b1, "clr2");

      // Asynchronous reset mid-burst at count 7
      for (int i = 0; i < 9; i++) cyc(1'b0, '0, 1'b1, 1'b0, "to7");
      chk("count_7", 32'(fifo_cnt), 32'd7);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk_all("async_rst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      cyc(1'b1, 8'h33, 1'b0, 1'b0, "wr_33");
      cyc(1'b0, '0, 1'b1, 1'b0, "rd_33");
`ifndef SYNC_FIFO_FWFT_EN
      chk("rd_33_dout", 32'(data_out), 32'h33);
`endif

      // Random traffic with varying read/write bias
      for (int i = 0; i < 600; i++) begin
         int wb;
         wb = (i / 100) % 3;
         cyc(($urandom_range(0, 9) < (wb == 0 ? 8 : (wb == 1 ? 3 : 5))),
             DW'($urandom), ($urandom_range(0, 9) < (wb == 0 ? 3 : (wb == 1 ? 8 : 5))),
             ($urandom_range(0, 19) == 0), "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
